// File: rtl/dpd_lms_adapt.sv
// dpd_lms_adapt: LMS adaptation of 15 complex DPD coefficients.
// Build macro DPD_LMS_LEAK_EN adds per-update coefficient leakage.
typedef struct packed {
  logic [0:14][19:0] i;
  logic [0:14][19:0] q;
} intf_coef_3_5;

module dpd_lms_adapt #(
  parameter int                 IDENT_IDX  = 0,
  parameter logic signed [19:0] UNITY      = 20'sh40000,
  parameter int                 LEAK_SHIFT = 16
) (
  input  logic               clk,
  input  logic               reset_b,
  input  intf_coef_3_5       yy,
  input  logic signed [19:0] err_i,
  input  logic signed [19:0] err_q,
  input  logic               upd_stb,
  input  logic [3:0]         mu_shift,
  input  logic               freeze,
  input  logic               clear,
  output intf_coef_3_5       coeff,
  output logic               busy,
  output logic               overrun,
  output logic [15:0]        upd_cnt
);

  localparam int NT = 15;
  localparam logic signed [31:0] ACC_UNITY = {UNITY, 12'h000};
  localparam logic signed [41:0] SMAX = 42'sd2147483647;
  localparam logic signed [41:0] SMIN = -42'sd2147483648;

  typedef enum logic [1:0] { IDLE, CALC, COMMIT } state_e;

  if (IDENT_IDX >= NT || LEAK_SHIFT > 31) begin : g_bad_param
    $error("dpd_lms_adapt: IDENT_IDX or LEAK_SHIFT out of range");
  end

  function automatic intf_coef_3_5 coef_rst();
    intf_coef_3_5 c;
    c = '0;
    c.i[IDENT_IDX] = UNITY;
    return c;
  endfunction

  function automatic logic signed [31:0] acc_upd(
    input logic signed [31:0] a,
    input logic signed [40:0] d
  );
    logic signed [41:0] s;
    s = 42'(a) + 42'(d);
`ifdef DPD_LMS_LEAK_EN
    s = s - 42'(a >>> LEAK_SHIFT);
`endif
    if (s > SMAX) return SMAX[31:0];
    if (s < SMIN) return SMIN[31:0];
    return s[31:0];
  endfunction

  state_e       state_q;
  logic         busy_q;
  logic         overrun_q;
  logic [15:0]  cnt_q;
  logic [3:0]   idx_q;

  intf_coef_3_5       ys_q, ys_d;
  logic signed [19:0] ei_q, ei_d;
  logic signed [19:0] eq_q, eq_d;
  logic [3:0]         mu_q, mu_d;

  logic               s1_vld_q, s1_vld_d;
  logic [3:0]         s1_idx_q, s1_idx_d;
  logic signed [39:0] pii_q, pii_d;
  logic signed [39:0] pqq_q, pqq_d;
  logic signed [39:0] piq_q, piq_d;
  logic signed [39:0] pqi_q, pqi_d;

  logic signed [31:0] acci_q [NT];
  logic signed [31:0] acci_d [NT];
  logic signed [31:0] accq_q [NT];
  logic signed [31:0] accq_d [NT];
  intf_coef_3_5       coef_q, coef_d;

  logic accept;
  logic issue;
  logic last;
  assign accept = (state_q == IDLE) && upd_stb && !freeze && !clear;
  assign issue  = (state_q == CALC) && (idx_q < 4'(NT));
  assign last   = s1_vld_q && (s1_idx_q == 4'(NT - 1));

  logic [3:0]         sel;
  logic signed [39:0] yi_x, yq_x, ei_x, eq_x;
  assign sel  = issue ? idx_q : 4'd0;
  assign yi_x = 40'(signed'(ys_q.i[sel]));
  assign yq_x = 40'(signed'(ys_q.q[sel]));
  assign ei_x = 40'(ei_q);
  assign eq_x = 40'(eq_q);

  logic signed [40:0] pi_s, pq_s, di_s, dq_s;
  logic [5:0]         sh;
  assign pi_s = 41'(pii_q) + 41'(pqq_q);
  assign pq_s = 41'(piq_q) - 41'(pqi_q);
  assign sh   = 6'd19 + 6'(mu_q);
  assign di_s = pi_s >>> sh;
  assign dq_s = pq_s >>> sh;

  // Control FSM: accept, sequence 15 indices, commit, sticky overrun.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else if (clear) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (upd_stb && state_q != IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        IDLE: if (accept) begin
          state_q <= CALC;
          busy_q  <= 1'b1;
          idx_q   <= '0;
        end
        CALC: begin
          if (issue) idx_q <= idx_q + 4'd1;
          if (last) state_q <= COMMIT;
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Snapshot of operands on the accepting edge.
  always_comb begin
    ys_d = ys_q;
    ei_d = ei_q;
    eq_d = eq_q;
    mu_d = mu_q;
    if (accept) begin
      ys_d = yy;
      ei_d = err_i;
      eq_d = err_q;
      mu_d = mu_shift;
    end
  end

  // Multiplier stage 1: partial products of conj(y)*e.
  always_comb begin
    s1_vld_d = issue && !clear;
    s1_idx_d = idx_q;
    pii_d    = yi_x * ei_x;
    pqq_d    = yq_x * eq_x;
    piq_d    = yi_x * eq_x;
    pqi_d    = yq_x * ei_x;
  end

  // Stage 2: scale and saturating accumulate into the shadow set.
  always_comb begin
    acci_d = acci_q;
    accq_d = accq_q;
    if (clear) begin
      for (int k = 0; k < NT; k++) begin
        acci_d[k] = (k == IDENT_IDX) ? ACC_UNITY : '0;
        accq_d[k] = '0;
      end
    end else if (s1_vld_q) begin
      acci_d[s1_idx_q] = acc_upd(acci_q[s1_idx_q], di_s);
      accq_d[s1_idx_q] = acc_upd(accq_q[s1_idx_q], dq_s);
    end
  end

  // Coefficient outputs move only on commit or clear.
  always_comb begin
    coef_d = coef_q;
    if (clear) begin
      coef_d = coef_rst();
    end else if (state_q == COMMIT) begin
      for (int k = 0; k < NT; k++) begin
        coef_d.i[k] = acci_q[k][31:12];
        coef_d.q[k] = accq_q[k][31:12];
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ys_q     <= '0;
      ei_q     <= '0;
      eq_q     <= '0;
      mu_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      pii_q    <= '0;
      pqq_q    <= '0;
      piq_q    <= '0;
      pqi_q    <= '0;
      for (int k = 0; k < NT; k++) begin
        acci_q[k] <= (k == IDENT_IDX) ? ACC_UNITY : '0;
        accq_q[k] <= '0;
      end
      coef_q   <= coef_rst();
    end else begin
      ys_q     <= ys_d;
      ei_q     <= ei_d;
      eq_q     <= eq_d;
      mu_q     <= mu_d;
      s1_vld_q <= s1_vld_d;
      s1_idx_q <= s1_idx_d;
      pii_q    <= pii_d;
      pqq_q    <= pqq_d;
      piq_q    <= piq_d;
      pqi_q    <= pqi_d;
      acci_q   <= acci_d;
      accq_q   <= accq_d;
      coef_q   <= coef_d;
    end
  end

  assign coeff   = coef_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign upd_cnt = cnt_q;

endmodule
